width_12to16: RTL and testbench

- Downstream neighbour of the 8-to-12 width converter. Consumes its 12-bit valid-qualified words and repacks them MSB-first into a continuous stream of 16-bit words.
- Adds ready/valid backpressure on the output side so a slower 16-bit consumer can stall the stream.
- Every 4 input words produce 3 output words (48-bit period).

---
 rtl/width_12to16.sv | 127 ++++++++++++
 tb/tb_width_12to16.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/width_12to16.sv
// Repacks a 12-bit valid-qualified stream MSB-first into 16-bit words behind a one-entry ready/valid output register.
// Optional residue flush is enabled by defining WIDTH_12TO16_FLUSH_EN.
module width_12to16 #(
  parameter int   CNT_W   = 16,
  parameter logic PAD_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [11:0]      data_in,
  output logic             in_ready,
  output logic             valid_out,
  output logic [15:0]      data_out,
  input  logic             out_ready,
`ifdef WIDTH_12TO16_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CNT_W-1:0] out_cnt,
  output logic [1:0]       phase_dbg
);

  // Phase names count the residue bits currently held.
  localparam logic [1:0] P0  = 2'd0;
  localparam logic [1:0] P12 = 2'd1;
  localparam logic [1:0] P8  = 2'd2;
  localparam logic [1:0] P4  = 2'd3;

  logic [1:0]       phase_q, phase_d;
  logic [11:0]      res_q, res_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, xfer, flush_req, flush_go, load;
  logic [15:0]      word;

  // valid/ready: a beat moves when valid and ready are both high on a rising edge;
  // valid_out holds with stable data_out until accepted, and in_ready never depends on valid_in.
  assign in_ready = !valid_q || out_ready;
  assign accept   = valid_in && in_ready;
  assign xfer     = valid_q && out_ready;

`ifdef WIDTH_12TO16_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign flush_go = flush_req && !accept && in_ready && (phase_q != P0);

  always_comb begin
    phase_d = phase_q;
    res_d   = res_q;
    load    = 1'b0;
    word    = 16'h0000;
    if (accept) begin
      case (phase_q)
        P0: begin
          res_d   = data_in;
          phase_d = P12;
        end
        P12: begin
          word    = {res_q, data_in[11:8]};
          res_d   = {4'h0, data_in[7:0]};
          phase_d = P8;
          load    = 1'b1;
        end
        P8: begin
          word    = {res_q[7:0], data_in[11:4]};
          res_d   = {8'h00, data_in[3:0]};
          phase_d = P4;
          load    = 1'b1;
        end
        default: begin
          word    = {res_q[3:0], data_in};
          res_d   = 12'h000;
          phase_d = P0;
          load    = 1'b1;
        end
      endcase
    end else if (flush_go) begin
      // Residue goes out left-aligned so its first bit stays in the MSB.
      case (phase_q)
        P12:     word = {res_q, {4{PAD_BIT}}};
        P8:      word = {res_q[7:0], {8{PAD_BIT}}};
        default: word = {res_q[3:0], {12{PAD_BIT}}};
      endcase
      res_d   = 12'h000;
      phase_d = P0;
      load    = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = word;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= P0;
      res_q   <= 12'h000;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign out_cnt   = cnt_q;
  assign phase_dbg = phase_q;

endmodule

// File: tb/tb_width_12to16.sv
// Bench for width_12to16: directed packing/backpressure/reset/wrap steps plus random traffic
// against a bit-stream reference model and an expected-word queue.
module tb_width_12to16;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_in;
  logic [11:0]      data_in;
  logic             in_ready;
  logic             valid_out;
  logic [15:0]      data_out;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] out_cnt;
  logic [1:0]       phase_dbg;

  width_12to16 #(.CNT_W(CNT_W), .PAD_BIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .out_ready (out_ready),
`ifdef WIDTH_12TO16_FLUSH_EN
    .flush     (flush),
`endif
    .out_cnt   (out_cnt),
    .phase_dbg (phase_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain bit stream plus the queue of words owed downstream.
  logic [15:0]      exp_q[$];
  logic [63:0]      bbuf;
  int               nbits;
  logic             m_valid;
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] cnt_seen[$];
  logic             acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bbuf    = 64'h0;
    nbits   = 0;
    m_valid = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in  = 1'b0;
    data_in   = 12'h000;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_reset();
    check("rst_valid_out", {31'b0, valid_out}, 32'h0);
    check("rst_data_out", {16'b0, data_out}, 32'h0);
    check("rst_out_cnt", 32'(out_cnt), 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic v, input logic [11:0] d, input logic r, input logic f,
                       output logic accepted);
    logic       xf;
    logic       formed;
    logic [15:0] w;
    valid_in  = v;
    data_in   = d;
    out_ready = r;
    flush     = f;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || r)});
    @(posedge clk);
    accepted = v && (!m_valid || r);
    xf       = m_valid && r;
    formed   = 1'b0;
    if (xf) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 1'b0;
      m_cnt   = m_cnt + 1'b1;
    end
    if (accepted) begin
      bbuf  = (bbuf << 12) | {52'h0, d};
      nbits = nbits + 12;
      if (nbits >= 16) begin
        w      = 16'(bbuf >> (nbits - 16));
        nbits  = nbits - 16;
        bbuf   = bbuf & ((64'd1 << nbits) - 64'd1);
        formed = 1'b1;
        exp_q.push_back(w);
      end
    end
`ifdef WIDTH_12TO16_FLUSH_EN
    else if (f && (!m_valid || r) && nbits > 0) begin
      w      = 16'(bbuf << (16 - nbits));
      nbits  = 0;
      bbuf   = 64'h0;
      formed = 1'b1;
      exp_q.push_back(w);
    end
`endif
    if (formed) m_valid = 1'b1;
    #1;
    check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    if (m_valid && exp_q.size() > 0) check("data_out", {16'b0, data_out}, {16'b0, exp_q[0]});
    check("out_cnt", 32'(out_cnt), 32'(m_cnt));
    if (xf) cnt_seen.push_back(out_cnt);
  endtask

  task automatic send(input logic [11:0] d, input logic r);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, d, r, 1'b0, a);
      n++;
    end
    if (!a) check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'h000, r, 1'b0, acc);
  endtask

  initial begin
    logic [CNT_W-1:0] cnt0;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in   = 12'h000;
    out_ready = 1'b0;
    flush     = 1'b0;
    do_reset();

    // Basic packing
    send(12'hA01, 1'b1);
    check("basic_no_out_after_1", {31'b0, valid_out}, 32'h0);
    send(12'hB23, 1'b1);
    check("basic_w0", {16'b0, data_out}, 32'hA01B);
    send(12'hC45, 1'b1);
    check("basic_w1", {16'b0, data_out}, 32'h23C4);
    send(12'hD67, 1'b1);
    check("basic_w2", {16'b0, data_out}, 32'h5D67);
    idle(2, 1'b1);
    check("basic_cnt", 32'(out_cnt), 32'h3);

    // Backpressure from word 2
    cnt0 = out_cnt;
    send(12'hA01, 1'b1);
    send(12'hB23, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 12'hC45, 1'b0, 1'b0, acc);
      check("bp_not_accepted", {31'b0, acc}, 32'h0);
      check("bp_hold_data", {16'b0, data_out}, 32'hA01B);
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
    end
    send(12'hC45, 1'b1);
    send(12'hD67, 1'b1);
    idle(2, 1'b1);
    check("bp_total", 32'(out_cnt - cnt0), 32'(CNT_W'(3)));

    // Gapped input
    send(12'hA01, 1'b1); idle(2, 1'b1);
    send(12'hB23, 1'b1);
    check("gap_w0", {16'b0, data_out}, 32'hA01B);
    idle(2, 1'b1);
    send(12'hC45, 1'b1);
    check("gap_w1", {16'b0, data_out}, 32'h23C4);
    idle(2, 1'b1);
    send(12'hD67, 1'b1);
    check("gap_w2", {16'b0, data_out}, 32'h5D67);
    idle(2, 1'b1);

    // Reset mid-operation
    send(12'hA01, 1'b0);
    send(12'hB23, 1'b0);
    do_reset();
    send(12'h123, 1'b1);
    send(12'h456, 1'b1);
    check("rst_mid_word", {16'b0, data_out}, 32'h1234);
    idle(2, 1'b1);

`ifdef WIDTH_12TO16_FLUSH_EN
    do_reset();
    send(12'hABC, 1'b1);
    cycle(1'b0, 12'h000, 1'b1, 1'b1, acc);
    check("flush_word", {16'b0, data_out}, 32'hABC0);
    cycle(1'b0, 12'h000, 1'b1, 1'b1, acc);
    check("flush_p0_noop", {31'b0, valid_out}, 32'h0);
    send(12'h111, 1'b1);
    send(12'h222, 1'b1);
    check("flush_after", {16'b0, data_out}, 32'h1112);
    idle(2, 1'b1);
`endif

    // Counter wrap
    do_reset();
    cnt_seen.delete();
    for (int i = 0; i < 8; i++) send(12'(12'h100 + i), 1'b1);
    idle(2, 1'b1);
    check("wrap_count", cnt_seen.size(), 32'd6);
    if (cnt_seen.size() >= 5) begin
      check("wrap_0", 32'(cnt_seen[0]), 32'd1);
      check("wrap_1", 32'(cnt_seen[1]), 32'd2);
      check("wrap_2", 32'(cnt_seen[2]), 32'd3);
      check("wrap_3", 32'(cnt_seen[3]), 32'd0);
      check("wrap_4", 32'(cnt_seen[4]), 32'd1);
    end

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), acc);
    end
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
